// File: rtl/led_pkg.sv
// Shared types for the LED PWM bank.
// led_mode_t encodes the per-channel drive mode written through the config port.
package led_pkg;

   typedef enum logic [1:0] {
      MODE_OFF   = 2'b00,
      MODE_ON    = 2'b01,
      MODE_BLINK = 2'b10,
      MODE_PWM   = 2'b11
   } led_mode_t;

endpackage

// File: rtl/led_prescaler.sv
// Blink prescaler: counts 0..CLK_DIV-1 and wraps.
// Ports:
//   clk   - clock, rising edge
//   reset - synchronous active-high reset
//   tick  - registered one-cycle pulse in the cycle after the count reaches CLK_DIV-1
module led_prescaler #(
   parameter int unsigned CLK_DIV = 10_000_000
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            tick_q, tick_d;
   logic            wrap;

   always_comb begin
      wrap   = (cnt_q == CntW'(CLK_DIV - 1));
      cnt_d  = wrap ? '0 : cnt_q + CntW'(1);
      tick_d = wrap;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/led_pwm_bank.sv
// Bank of N_CH LED channels, each OFF, ON, BLINK (shared phase) or PWM (per-channel duty).
// Ports:
//   clk, reset - clock and synchronous active-high reset
//   cfg_we     - one-cycle write strobe for channel cfg_ch
//   cfg_ch     - target channel; values >= N_CH are rejected with a cfg_err pulse
//   cfg_mode   - led_mode_t encoding of the new mode
//   cfg_duty   - PWM duty; led high while pwm_cnt < duty
//   led        - registered LED drive, one bit per channel
//   tick       - one-cycle pulse marking each blink phase toggle
//   cfg_err    - one-cycle pulse after a write to an invalid channel
module led_pwm_bank
   import led_pkg::*;
#(
   parameter int unsigned N_CH    = 3,
   parameter int unsigned CLK_DIV = 10_000_000,
   parameter int unsigned PWM_W   = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cfg_we,
   input  logic [3:0]       cfg_ch,
   input  logic [1:0]       cfg_mode,
   input  logic [PWM_W-1:0] cfg_duty,
   output logic [N_CH-1:0]  led,
   output logic             tick,
   output logic             cfg_err
);

   led_mode_t        mode_q [N_CH];
   led_mode_t        mode_d [N_CH];
   logic [PWM_W-1:0] duty_q [N_CH];
   logic [PWM_W-1:0] duty_d [N_CH];
   logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
   logic             blink_phase_q, blink_phase_d;
   logic [N_CH-1:0]  led_q, led_d;
   logic             err_q, err_d;
   logic             ch_valid;
   logic             tick_w;

   led_prescaler #(
      .CLK_DIV (CLK_DIV)
   ) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .tick  (tick_w)
   );

   always_comb begin
      ch_valid      = (32'(cfg_ch) < N_CH);
      pwm_cnt_d     = pwm_cnt_q + PWM_W'(1);
      // Phase flips once per prescaler period, in the cycle marked by tick.
      blink_phase_d = blink_phase_q ^ tick_w;
      err_d         = cfg_we && !ch_valid;
      mode_d        = mode_q;
      duty_d        = duty_q;
      for (int i = 0; i < N_CH; i++) begin
         if (cfg_we && ch_valid && (cfg_ch == 4'(i))) begin
            mode_d[i] = led_mode_t'(cfg_mode);
            duty_d[i] = cfg_duty;
         end
      end
   end

   // LED drive uses the stored config, so a write shows up one edge later.
   always_comb begin
      led_d = '0;
      for (int i = 0; i < N_CH; i++) begin
         unique case (mode_q[i])
            MODE_OFF:   led_d[i] = 1'b0;
            MODE_ON:    led_d[i] = 1'b1;
            MODE_BLINK: led_d[i] = blink_phase_q;
            MODE_PWM:   led_d[i] = (pwm_cnt_q < duty_q[i]);
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N_CH; i++) begin
            mode_q[i] <= MODE_OFF;
            duty_q[i] <= '0;
         end
         pwm_cnt_q     <= '0;
         blink_phase_q <= 1'b0;
         led_q         <= '0;
         err_q         <= 1'b0;
      end else begin
         mode_q        <= mode_d;
         duty_q        <= duty_d;
         pwm_cnt_q     <= pwm_cnt_d;
         blink_phase_q <= blink_phase_d;
         led_q         <= led_d;
         err_q         <= err_d;
      end
   end

   assign led     = led_q;
   assign tick    = tick_w;
   assign cfg_err = err_q;

endmodule

// File: tb/tb_led_pwm_bank.sv
// Randomised and directed bench for led_pwm_bank with a cycle-count based reference model.
module tb_led_pwm_bank;

   localparam int N = 3;
   localparam int D = 4;
   localparam int W = 2;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         cfg_we = 1'b0;
   logic [3:0]   cfg_ch = '0;
   logic [1:0]   cfg_mode = '0;
   logic [W-1:0] cfg_duty = '0;
   logic [N-1:0] led;
   logic         tick;
   logic         cfg_err;

   led_pwm_bank #(
      .N_CH    (N),
      .CLK_DIV (D),
      .PWM_W   (W)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .cfg_we   (cfg_we),
      .cfg_ch   (cfg_ch),
      .cfg_mode (cfg_mode),
      .cfg_duty (cfg_duty),
      .led      (led),
      .tick     (tick),
      .cfg_err  (cfg_err)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   // Model state: edges elapsed since reset plus the stored per-channel config.
   int           t_m = 0;
   int           mode_m [N];
   int           duty_m [N];
   logic [N-1:0] led_m = '0;
   logic         err_m = 1'b0;

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
   endtask

   // Tick is high when t is a positive multiple of D; the phase flips on the edge after each tick.
   function automatic int phase_at(input int t);
      return (t == 0) ? 0 : ((t - 1) / D) % 2;
   endfunction

   task automatic cyc(input logic r, input logic we, input int ch, input int md, input int dt);
      reset    = r;
      cfg_we   = we;
      cfg_ch   = 4'(ch);
      cfg_mode = 2'(md);
      cfg_duty = W'(dt);
      @(posedge clk);
      #1;
      if (r) begin
         t_m = 0;
         for (int i = 0; i < N; i++) begin
            mode_m[i] = 0;
            duty_m[i] = 0;
         end
         led_m = '0;
         err_m = 1'b0;
      end else begin
         for (int i = 0; i < N; i++) begin
            case (mode_m[i])
               0:       led_m[i] = 1'b0;
               1:       led_m[i] = 1'b1;
               2:       led_m[i] = phase_at(t_m) != 0;
               default: led_m[i] = (t_m % (1 << W)) < duty_m[i];
            endcase
         end
         err_m = we && (ch >= N);
         if (we && ch < N) begin
            mode_m[ch] = md;
            duty_m[ch] = dt;
         end
         t_m++;
      end
      check("led", int'(led), int'(led_m));
      check("tick", int'(tick), (t_m > 0 && t_m % D == 0) ? 1 : 0);
      check("cfg_err", int'(cfg_err), int'(err_m));
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 0, 0, 0);
   endtask

   task automatic pwm_window(input int duty, input int exp_hi);
      int hi;
      hi = 0;
      cyc(1'b0, 1'b1, 1, 3, duty);
      idle();
      for (int k = 0; k < 8; k++) begin
         idle();
         hi += int'(led[1]);
      end
      check("pwm_high_count", hi, exp_hi);
   endtask

   initial begin
      int toggles;
      logic prev;

      // Reset held for 3 cycles, then one cycle after release.
      repeat (3) cyc(1'b1, 1'b0, 0, 0, 0);
      check("rst_led", int'(led), 0);
      idle();
      check("post_rst_led", int'(led), 0);

      // ON then OFF on channel 1.
      cyc(1'b0, 1'b1, 1, 1, 0);
      idle();
      check("scn_on", int'(led), 2);
      cyc(1'b0, 1'b1, 1, 0, 0);
      idle();
      check("scn_off", int'(led), 0);

      // Two blinking channels share one phase.
      cyc(1'b0, 1'b1, 0, 2, 0);
      cyc(1'b0, 1'b1, 2, 2, 0);
      idle();
      toggles = 0;
      prev = led[0];
      for (int k = 0; k < 16; k++) begin
         idle();
         if (led[0] != prev) toggles++;
         prev = led[0];
      end
      check("blink_toggles", toggles, 4);
      cyc(1'b0, 1'b1, 0, 0, 0);
      cyc(1'b0, 1'b1, 2, 0, 0);

      // PWM duty boundaries on channel 1.
      pwm_window(1, 2);
      pwm_window(3, 6);
      pwm_window(0, 0);

      // Invalid channel and reset priority.
      cyc(1'b0, 1'b1, 1, 1, 0);
      idle();
      cyc(1'b0, 1'b1, 5, 0, 0);
      check("err_pulse", int'(cfg_err), 1);
      check("err_led_kept", int'(led), 2);
      idle();
      check("err_clear", int'(cfg_err), 0);
      cyc(1'b1, 1'b1, 0, 1, 0);
      check("rst_prio_led", int'(led), 0);
      idle();
      idle();
      check("rst_prio_after", int'(led), 0);

      // Random traffic, including invalid channels and occasional resets.
      for (int k = 0; k < 600; k++) begin
         cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
             int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, (1 << W) - 1)));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
